// File: rtl/mips_mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: ALU codes, opcode/funct values, FSM states.
// Optional ANDI/ORI support is enabled by defining MC_CTRL_ANDI_ORI_EN.
package mips_mc_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_LOGIEX  = 4'd12;

    typedef enum logic [2:0] {
        AOP_NONE  = 3'd0,
        AOP_ADD   = 3'd1,
        AOP_SUB   = 3'd2,
        AOP_FUNCT = 3'd3,
        AOP_AND   = 3'd4,
        AOP_OR    = 3'd5
    } aluop_t;

    // Opcode dispatch out of DECODE; returning FETCH marks the opcode as unsupported.
    function automatic logic [3:0] decode_next(input logic [5:0] op);
        logic [3:0] nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_RTYPEEX;
            OP_BEQ:       nxt = S_BEQEX;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JEX;
`ifdef MC_CTRL_ANDI_ORI_EN
            OP_ANDI, OP_ORI: nxt = S_LOGIEX;
`endif
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's ALU request (and funct for R-type) onto ALUcont.
module mips_mc_ctrl_alu_dec
    import mips_mc_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int ALUC_W = 3
) (
    input  aluop_t            aluop,
    input  logic [OP_W-1:0]   funct,
    output logic [ALUC_W-1:0] alucont
);

    // Unknown R-type funct falls back to ADD; states with no ALU use drive zero.
    always_comb begin
        alucont = '0;
        case (aluop)
            AOP_ADD: alucont = ALUC_W'(ALU_ADD);
            AOP_SUB: alucont = ALUC_W'(ALU_SUB);
            AOP_AND: alucont = ALUC_W'(ALU_AND);
            AOP_OR:  alucont = ALUC_W'(ALU_OR);
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucont = ALUC_W'(ALU_ADD);
                    FN_SUB:  alucont = ALUC_W'(ALU_SUB);
                    FN_AND:  alucont = ALUC_W'(ALU_AND);
                    FN_OR:   alucont = ALUC_W'(ALU_OR);
                    FN_SLT:  alucont = ALUC_W'(ALU_SLT);
                    default: alucont = ALUC_W'(ALU_ADD);
                endcase
            end
            default: alucont = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared-ALU datapath.
// Defining MC_CTRL_ANDI_ORI_EN adds ANDI/ORI support and the ImmZext output.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   funct,
    input  logic              zero,
    output logic [ALUC_W-1:0] ALUcont,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        PCSrc,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              PCEn,
`ifdef MC_CTRL_ANDI_ORI_EN
    output logic              ImmZext,
`endif
    output logic              illegal
);

    logic [3:0] state_q, state_d, dec_next_s;
    aluop_t     aluop_s;
    logic       alusrca_s, iord_s, memwrite_s, irwrite_s, regdst_s, memtoreg_s;
    logic       regwrite_s, pcwrite_s, branch_s, illegal_s;
    logic [1:0] alusrcb_s, pcsrc_s;
`ifdef MC_CTRL_ANDI_ORI_EN
    logic       immzext_s;
`endif

    assign dec_next_s = decode_next(6'(op));

    // Next-state and Moore output decode from the current state.
    always_comb begin
        state_d    = S_FETCH;
        aluop_s    = AOP_NONE;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'd0;
        pcsrc_s    = 2'd0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        illegal_s  = 1'b0;
`ifdef MC_CTRL_ANDI_ORI_EN
        immzext_s  = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                alusrcb_s = 2'd1;
                aluop_s   = AOP_ADD;
                pcwrite_s = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_s = 2'd3;
                aluop_s   = AOP_ADD;
                state_d   = dec_next_s;
                illegal_s = (dec_next_s == S_FETCH);
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'd2;
                aluop_s   = AOP_ADD;
                if (6'(op) == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (6'(op) == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord_s  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca_s = 1'b1;
                aluop_s   = AOP_FUNCT;
                state_d   = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca_s = 1'b1;
                aluop_s   = AOP_SUB;
                branch_s  = 1'b1;
                pcsrc_s   = 2'd1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'd2;
                aluop_s   = AOP_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc_s   = 2'd2;
                pcwrite_s = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_CTRL_ANDI_ORI_EN
            S_LOGIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'd2;
                aluop_s   = (6'(op) == OP_ANDI) ? AOP_AND : AOP_OR;
                immzext_s = 1'b1;
                state_d   = S_ADDIWB;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register; reset lands in FETCH and aborts any instruction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mips_mc_ctrl_alu_dec #(
        .OP_W   (OP_W),
        .ALUC_W (ALUC_W)
    ) u_alu_dec (
        .aluop   (aluop_s),
        .funct   (funct),
        .alucont (ALUcont)
    );

    assign ALUSrcA  = alusrca_s;
    assign ALUSrcB  = alusrcb_s;
    assign PCSrc    = pcsrc_s;
    assign IorD     = iord_s;
    assign RegDst   = regdst_s;
    assign MemtoReg = memtoreg_s;
    assign illegal  = illegal_s;
    // Write enables are masked by resetn so nothing commits while reset is held.
    assign MemWrite = memwrite_s & resetn;
    assign IRWrite  = irwrite_s & resetn;
    assign RegWrite = regwrite_s & resetn;
    assign PCEn     = (pcwrite_s | (branch_s & zero)) & resetn;
`ifdef MC_CTRL_ANDI_ORI_EN
    assign ImmZext  = immzext_s;
`endif

endmodule
